// File: rtl/stabilizer_gate_sequencer_pkg.sv
// Shared definitions for the stabilizer gate sequencer: gate encodings,
// sequencer state type and default pipeline latencies.
package stabilizer_gate_sequencer_pkg;

  localparam logic [2:0] GATE_H    = 3'd0;
  localparam logic [2:0] GATE_P    = 3'd1;
  localparam logic [2:0] GATE_CNOT = 3'd2;

  localparam int DEF_RAM_LAT   = 1;
  localparam int DEF_ALPHA_LAT = 4;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_WAIT  = 2'd2,
    SEQ_WRITE = 2'd3
  } seq_state_t;

  // A gate is legal when its type is H/P/CNOT and the qubit index is in range.
  function automatic logic gate_is_legal(input logic [2:0]  gate_type,
                                         input logic [31:0] qubit_pos,
                                         input logic [31:0] qubit_limit);
    return (gate_type <= GATE_CNOT) && (qubit_pos < qubit_limit);
  endfunction

endpackage

// File: rtl/stabilizer_gate_sequencer_latency_counter.sv
// Loadable up-counter used to time the RAM + alpha datapath latency of one gate op.
// tc goes high once the count has reached the terminal value.
module seq_latency_counter #(
  parameter int W        = 4,
  parameter int TERMINAL = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;
  // >= rather than == so a zero terminal value still releases the wait state.
  assign tc    = (count_reg >= W'(TERMINAL));

endmodule

// File: rtl/stabilizer_gate_sequencer.sv
// Per-gate controller for the stabilizer alpha / global-phase datapath: accepts
// normalised Clifford gates, strobes the RAM read, samples alpha-zero, times the write.
module stabilizer_gate_sequencer
  import stabilizer_gate_sequencer_pkg::*;
#(
  parameter int num_qubit = 4,
  parameter int RAM_LAT   = DEF_RAM_LAT,
  parameter int ALPHA_LAT = DEF_ALPHA_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        circuit_start,
  input  logic        gate_valid,
  output logic        gate_ready,
  input  logic [2:0]  gate_type,
  input  logic [31:0] qubit_pos,
  output logic [2:0]  gate_type_norm,
  output logic [31:0] qubit_pos_norm,
  output logic        first_gate,
  output logic        ram_rd_en,
  input  logic        initial_alpha_zero,
  output logic        alpha_zero_valid,
  output logic        alpha_zero,
  output logic        amp_wr_en,
  output logic        gate_done,
  output logic        gate_err,
  output logic [15:0] gate_count
);

  localparam int          OP_LAT      = RAM_LAT + ALPHA_LAT;
  localparam int          CNT_W       = $clog2(OP_LAT + 2);
  localparam logic [31:0] QPOS_LIMIT  = 32'(num_qubit);

  seq_state_t  state_reg, state_next;

  logic        gate_ready_reg;
  logic [2:0]  gate_type_norm_reg;
  logic [31:0] qubit_pos_norm_reg;
  logic        first_gate_reg;
  logic        armed_reg;
  logic        alpha_zero_reg;
  logic        alpha_zero_valid_reg;
  logic        gate_err_reg;
  logic [15:0] gate_count_reg;

  logic        accept;
  logic        legal;
  logic        accept_legal;
  logic        sample_now;
  logic        lat_en;
  logic        lat_tc;
  logic [CNT_W-1:0] lat_count;

  // gate_ready_reg is only ever high in IDLE, so it alone qualifies an accept.
  assign accept       = gate_ready_reg && gate_valid;
  assign legal        = gate_is_legal(gate_type, qubit_pos, QPOS_LIMIT);
  assign accept_legal = accept && legal;
  assign lat_en       = (state_reg == SEQ_ISSUE) || (state_reg == SEQ_WAIT);

  seq_latency_counter #(
    .W        (CNT_W),
    .TERMINAL (OP_LAT - 1)
  ) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_legal),
    .en       (lat_en),
    .load_val ('0),
    .count    (lat_count),
    .tc       (lat_tc)
  );

  // Counter reads 0 during ISSUE, so RAM data is valid when it equals RAM_LAT.
  assign sample_now = lat_en && (lat_count == CNT_W'(RAM_LAT)) &&
                      (gate_type_norm_reg == GATE_H);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= SEQ_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ram_rd_en  = 1'b0;
    amp_wr_en  = 1'b0;
    gate_done  = 1'b0;
    case (state_reg)
      SEQ_IDLE: begin
        if (accept_legal) begin
          state_next = SEQ_ISSUE;
        end
      end
      SEQ_ISSUE: begin
        ram_rd_en  = 1'b1;
        state_next = SEQ_WAIT;
      end
      SEQ_WAIT: begin
        if (lat_tc) begin
          state_next = SEQ_WRITE;
        end
      end
      SEQ_WRITE: begin
        amp_wr_en  = 1'b1;
        gate_done  = 1'b1;
        state_next = SEQ_IDLE;
      end
      default: begin
        state_next = SEQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_ready_reg       <= 1'b0;
      gate_type_norm_reg   <= '0;
      qubit_pos_norm_reg   <= '0;
      first_gate_reg       <= 1'b0;
      armed_reg            <= 1'b1;
      alpha_zero_reg       <= 1'b0;
      alpha_zero_valid_reg <= 1'b0;
      gate_err_reg         <= 1'b0;
      gate_count_reg       <= '0;
    end else begin
      gate_ready_reg       <= (state_next == SEQ_IDLE);
      gate_err_reg         <= accept && !legal;
      alpha_zero_valid_reg <= sample_now;

      if (sample_now) begin
        alpha_zero_reg <= initial_alpha_zero;
      end

      // A circuit_start coincident with the accept makes this gate the first one.
      if (accept_legal) begin
        gate_type_norm_reg <= gate_type;
        qubit_pos_norm_reg <= qubit_pos;
        first_gate_reg     <= armed_reg || circuit_start;
        armed_reg          <= 1'b0;
      end else if (circuit_start) begin
        armed_reg <= 1'b1;
      end

      if (circuit_start) begin
        gate_count_reg <= '0;
      end else if (state_reg == SEQ_WRITE) begin
        gate_count_reg <= gate_count_reg + 16'd1;
      end
    end
  end

  assign gate_ready       = gate_ready_reg;
  assign gate_type_norm   = gate_type_norm_reg;
  assign qubit_pos_norm   = qubit_pos_norm_reg;
  assign first_gate       = first_gate_reg;
  assign alpha_zero       = alpha_zero_reg;
  assign alpha_zero_valid = alpha_zero_valid_reg;
  assign gate_err         = gate_err_reg;
  assign gate_count       = gate_count_reg;

endmodule

// File: tb/tb_stabilizer_gate_sequencer.sv
// Directed bench for stabilizer_gate_sequencer: cycle offsets of each strobe
// relative to the accept, first_gate handling, rejects, reset abort and count wrap.
module tb_stabilizer_gate_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        circuit_start = 1'b0;
  logic        gate_valid = 1'b0;
  logic [2:0]  gate_type = '0;
  logic [31:0] qubit_pos = '0;
  logic        initial_alpha_zero = 1'b0;

  logic        gate_ready;
  logic [2:0]  gate_type_norm;
  logic [31:0] qubit_pos_norm;
  logic        first_gate;
  logic        ram_rd_en;
  logic        alpha_zero_valid;
  logic        alpha_zero;
  logic        amp_wr_en;
  logic        gate_done;
  logic        gate_err;
  logic [15:0] gate_count;

  always #5 clk = ~clk;

  stabilizer_gate_sequencer #(
    .num_qubit (4),
    .RAM_LAT   (1),
    .ALPHA_LAT (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .circuit_start      (circuit_start),
    .gate_valid         (gate_valid),
    .gate_ready         (gate_ready),
    .gate_type          (gate_type),
    .qubit_pos          (qubit_pos),
    .gate_type_norm     (gate_type_norm),
    .qubit_pos_norm     (qubit_pos_norm),
    .first_gate         (first_gate),
    .ram_rd_en          (ram_rd_en),
    .initial_alpha_zero (initial_alpha_zero),
    .alpha_zero_valid   (alpha_zero_valid),
    .alpha_zero         (alpha_zero),
    .amp_wr_en          (amp_wr_en),
    .gate_done          (gate_done),
    .gate_err           (gate_err),
    .gate_count         (gate_count)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_miss = 0;

  int          acc_q[$];
  int          rd_q[$];
  int          wr_q[$];
  int          done_q[$];
  int          azv_q[$];
  int          err_q[$];
  logic        fg_rd_q[$];
  logic        fg_wr_q[$];
  logic [2:0]  type_wr_q[$];
  logic [31:0] pos_wr_q[$];
  logic        az_q[$];
  logic        ready_err_q[$];

  // Event log, sampled on the inactive edge.
  always @(negedge clk) begin
    if (gate_ready && gate_valid) acc_q.push_back(cyc);
    if (ram_rd_en) begin
      rd_q.push_back(cyc);
      fg_rd_q.push_back(first_gate);
    end
    if (amp_wr_en) begin
      wr_q.push_back(cyc);
      fg_wr_q.push_back(first_gate);
      type_wr_q.push_back(gate_type_norm);
      pos_wr_q.push_back(qubit_pos_norm);
    end
    if (gate_done) done_q.push_back(cyc);
    if (alpha_zero_valid) begin
      azv_q.push_back(cyc);
      az_q.push_back(alpha_zero);
    end
    if (gate_err) begin
      err_q.push_back(cyc);
      ready_err_q.push_back(gate_ready);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1000;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    acc_q.delete(); rd_q.delete(); wr_q.delete(); done_q.delete();
    azv_q.delete(); err_q.delete(); fg_rd_q.delete(); fg_wr_q.delete();
    type_wr_q.delete(); pos_wr_q.delete(); az_q.delete(); ready_err_q.delete();
  endtask

  task automatic pulse_start();
    circuit_start = 1'b1;
    step(1);
    circuit_start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!gate_ready && n < 40) begin
      step(1);
      n++;
    end
    if (!gate_ready) check("ready_timeout", 32'(gate_ready), 32'd1);
  endtask

  task automatic send_gate(input logic [2:0] t, input logic [31:0] q);
    wait_ready();
    $display("gate type=%0d qubit=%0d at cycle %0d", t, q, cyc);
    gate_valid = 1'b1;
    gate_type  = t;
    qubit_pos  = q;
    step(1);
    gate_valid = 1'b0;
  endtask

  logic [2:0]  b2b_type [3] = '{3'd1, 3'd2, 3'd0};
  logic [31:0] b2b_pos  [3] = '{32'd0, 32'd1, 32'd3};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(1);
    check("rst_flags", {24'd0, gate_ready, ram_rd_en, amp_wr_en, gate_done,
                        gate_err, first_gate, alpha_zero, alpha_zero_valid}, 32'd0);
    check("rst_count", 32'(gate_count), 32'd0);
    rst = 1'b0;
    step(1);
    check("ready_after_rst", 32'(gate_ready), 32'd1);

    // First H gate after circuit_start
    clear_log();
    pulse_start();
    send_gate(3'd0, 32'd2);
    step(9);
    check("t1_rd_ofs",   32'(qget(rd_q, 0) - qget(acc_q, 0)), 32'd1);
    check("t1_fg",       32'(fg_rd_q.size() > 0 ? fg_rd_q[0] : 1'b0), 32'd1);
    check("t1_azv_ofs",  32'(qget(azv_q, 0) - qget(acc_q, 0)), 32'd3);
    check("t1_wr_ofs",   32'(qget(wr_q, 0) - qget(acc_q, 0)), 32'd6);
    check("t1_done_ofs", 32'(qget(done_q, 0) - qget(acc_q, 0)), 32'd6);
    check("t1_n_rd",     32'(rd_q.size()), 32'd1);
    check("t1_pos_norm", pos_wr_q.size() > 0 ? pos_wr_q[0] : 32'hdead, 32'd2);
    check("t1_count",    32'(gate_count), 32'd1);

    // Back-to-back with gate_valid held high
    clear_log();
    pulse_start();
    gate_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      gate_type = b2b_type[i];
      qubit_pos = b2b_pos[i];
      wait_ready();
      $display("gate type=%0d qubit=%0d at cycle %0d", gate_type, qubit_pos, cyc);
      step(1);
    end
    gate_valid = 1'b0;
    step(9);
    check("t2_n_acc",  32'(acc_q.size()), 32'd3);
    check("t2_gap0",   32'(qget(acc_q, 1) - qget(acc_q, 0)), 32'd7);
    check("t2_gap1",   32'(qget(acc_q, 2) - qget(acc_q, 1)), 32'd7);
    check("t2_fg",     32'(fg_rd_q.size() == 3 ? {fg_rd_q[0], fg_rd_q[1], fg_rd_q[2]} : 3'b111), 32'b100);
    check("t2_type1",  32'(type_wr_q.size() > 1 ? type_wr_q[1] : 3'd7), 32'd2);
    check("t2_n_azv",  32'(azv_q.size()), 32'd1);
    check("t2_azv_ofs",32'(qget(azv_q, 0) - qget(acc_q, 2)), 32'd3);
    check("t2_count",  32'(gate_count), 32'd3);

    // Illegal type, then out-of-range qubit
    clear_log();
    send_gate(3'd5, 32'd0);
    step(2);
    send_gate(3'd0, 32'd4);
    step(3);
    check("t3_n_err",   32'(err_q.size()), 32'd2);
    check("t3_err0_ofs",32'(qget(err_q, 0) - qget(acc_q, 0)), 32'd1);
    check("t3_err1_ofs",32'(qget(err_q, 1) - qget(acc_q, 1)), 32'd1);
    check("t3_rdy_err", 32'(ready_err_q.size() > 0 ? ready_err_q[0] : 1'b0), 32'd1);
    check("t3_n_rdwr",  32'(rd_q.size() + wr_q.size()), 32'd0);
    check("t3_count",   32'(gate_count), 32'd3);

    // alpha_zero capture: H captures, P does not
    clear_log();
    initial_alpha_zero = 1'b1;
    send_gate(3'd0, 32'd1);
    step(9);
    check("t4_h_az",    32'(az_q.size() > 0 ? az_q[0] : 1'b0), 32'd1);
    check("t4_h_nazv",  32'(azv_q.size()), 32'd1);
    clear_log();
    send_gate(3'd1, 32'd3);
    step(9);
    check("t4_p_nazv",  32'(azv_q.size()), 32'd0);
    clear_log();
    initial_alpha_zero = 1'b0;
    send_gate(3'd1, 32'd0);
    step(9);
    check("t4_p_hold",  32'(alpha_zero), 32'd1);
    clear_log();
    send_gate(3'd0, 32'd0);
    step(9);
    check("t4_h_az0",   32'(alpha_zero), 32'd0);
    check("t4_count",   32'(gate_count), 32'd7);

    // Reset in the middle of WAIT aborts the op
    clear_log();
    send_gate(3'd0, 32'd1);
    step(2);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_flags", {24'd0, gate_ready, ram_rd_en, amp_wr_en, gate_done,
                           gate_err, first_gate, alpha_zero, alpha_zero_valid}, 32'd0);
    check("t5_rst_norm",  {gate_type_norm, qubit_pos_norm[28:0]}, 32'd0);
    check("t5_rst_count", 32'(gate_count), 32'd0);
    step(2);
    rst = 1'b0;
    step(6);
    check("t5_no_wr",     32'(wr_q.size() + done_q.size()), 32'd0);
    clear_log();
    send_gate(3'd2, 32'd3);
    step(9);
    check("t5_fg",        32'(fg_rd_q.size() > 0 ? fg_rd_q[0] : 1'b0), 32'd1);
    check("t5_wr_ofs",    32'(qget(wr_q, 0) - qget(acc_q, 0)), 32'd6);
    check("t5_count",     32'(gate_count), 32'd1);

    // gate_count wraps from 0xFFFF
    force dut.gate_count_reg = 16'hffff;
    step(1);
    release dut.gate_count_reg;
    step(1);
    clear_log();
    send_gate(3'd1, 32'd0);
    step(9);
    check("t6_wrap",      32'(gate_count), 32'd0);

    // circuit_start during WAIT leaves the running op alone
    clear_log();
    send_gate(3'd1, 32'd2);
    step(1);
    pulse_start();
    step(8);
    check("t6_mid_wr_ofs", 32'(qget(wr_q, 0) - qget(acc_q, 0)), 32'd6);
    check("t6_mid_fg",     32'(fg_wr_q.size() > 0 ? {fg_rd_q[0], fg_wr_q[0]} : 2'b11), 32'd0);
    check("t6_mid_pos",    pos_wr_q.size() > 0 ? pos_wr_q[0] : 32'hdead, 32'd2);
    check("t6_mid_count",  32'(gate_count), 32'd1);
    clear_log();
    send_gate(3'd0, 32'd0);
    step(9);
    check("t6_next_fg",    32'(fg_rd_q.size() > 0 ? fg_rd_q[0] : 1'b0), 32'd1);
    check("t6_next_count", 32'(gate_count), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
